regbank_wr_arbiter: RTL and testbench
=====================================

// Module: regbank_wr_arbiter
// PURPOSE
//  Shares one bank of NREG enabled D-flip-flop registers (sync enable, sync reset)
//  between NREQ write requesters.
//  - Round-robin arbitration, one accepted write per cycle.
//  - Accepted writes become a registered one-hot enable plus data for the bank.
//  - A requester may lock the bank for an atomic multi-write sequence.
//  - Sits between the requesting engines and the register bank; it is the only
//    driver of the bank's EN and D inputs.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  NREG     8   number of registers in the bank (>=2)
//  DW       8   register data width
//  LOCK_MAX 16  max cycles a lock may be held before forced release (>=1)
// PORTS
//  clk        in   1          clock, all state on posedge
//  reset      in   1          synchronous, active-high
//  req_valid  in   NREQ       per-requester write request
//  req_lock   in   NREQ       keep ownership after this write
//  req_addr   in   NREQ*AW    register index; AW = max(1,$clog2(NREG)); slice i = requester i
//  req_data   in   NREQ*DW    write data, slice i = requester i
//  req_ready  out  NREQ       one-hot grant, combinational; a write is accepted on valid&ready
//  reg_en     out  NREG       one-hot write enable to the bank, registered
//  reg_d      out  DW         write data to the bank, registered
//  addr_err   out  1          pulse: accepted write had addr >= NREG, registered
//  locked     out  1          1 while in OWNED state
//  owner      out  $clog2(NREQ)  current or last grant index
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, owner=0, reg_en=0, reg_d=0, addr_err=0,
//    locked=0, lock_cnt=0. req_ready=0 during reset.
//  - Arbitration (IDLE): winner = first i with req_valid[i], searching rr_ptr,
//    rr_ptr+1, ... mod NREQ. req_ready[winner]=1 in the same cycle; all other bits 0.
//    No valid -> req_ready=0.
//  - On accept at cycle t:
//    - rr_ptr <= winner+1 (mod NREQ); owner <= winner.
//    - In cycle t+1: reg_en = onehot(addr) for one cycle, reg_d = data.
//      The bank captures at the end of t+1. Latency: request to bank update = 2 edges.
//    - addr >= NREG: reg_en stays 0, addr_err=1 for one cycle in t+1; still
//      counts as accepted.
//  - No accept: reg_en=0, addr_err=0. reg_d holds its last value.
//  - FSM IDLE -> OWNED: accept with req_lock[winner]=1. lock_cnt <= 0.
//  - OWNED:
//    - Only owner may be granted: req_ready[owner]=req_valid[owner]. Other requests stall.
//    - lock_cnt increments every cycle.
//    - OWNED -> IDLE when the owner is accepted with req_lock=0 (that write still proceeds).
//    - OWNED -> IDLE when lock_cnt reaches LOCK_MAX-1 with no such accept. The forced
//      release cycle grants nothing; rr_ptr <= owner+1.
//    - An owner write accepted with lock=1 in the expiry cycle is performed, then released.
//  - Boundaries:
//    - Simultaneous valid from all requesters -> strict rotation, no starvation.
//    - rr_ptr wraps NREQ-1 -> 0.
//    - Reset mid-lock or with a write pending in the output register: state IDLE
//      next cycle, pending reg_en dropped (0), no bank write.
//  - locked = (state==OWNED).
// STRUCTURE
//  - Shared package regbank_pkg: state enum {IDLE, OWNED}, onehot function.
//  - Sub-module rr_pick (combinational round-robin priority picker: req, ptr -> gnt,
//    idx). Reused by other arbiters.
//  - Top level: FSM, lock counter, output registers.
// TESTING
//  1. Reset then single req: req_valid=0001, addr=3, data=8'hA5
//     -> req_ready=0001 same cycle; next cycle reg_en=8'h08, reg_d=A5.
//  2. All valid for 8 cycles, no lock -> grants 0,1,2,3,0,1,2,3; reg_en pulses every cycle.
//  3. Lock: req1 lock=1 for 3 writes, req0/2 valid throughout -> only req1 granted;
//     4th write with lock=0 releases; next grant goes to req2.
//  4. Lock timeout: LOCK_MAX=4, req2 locks then drops valid -> locked falls after 4
//     cycles; next grant goes to req3 if valid.
//  5. Out of range: NREG=6, addr=7 -> req_ready asserted; next cycle reg_en=0, addr_err=1.
//  6. Reset asserted the cycle after accept -> reg_en stays 0, locked=0, next grant starts
//     from req0.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// Holds the arbiter FSM state encoding and a one-hot decode helper.
package regbank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   localparam int OH_W = 256;

   function automatic logic [OH_W-1:0] onehot(input int unsigned idx);
      return OH_W'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Returns the first set request at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter with bank locking for a shared register bank.
// Produces a registered one-hot enable and data word for the bank.
module regbank_wr_arbiter
   import regbank_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int NREG     = 8,
   parameter int DW       = 8,
   parameter int LOCK_MAX = 16,
   parameter int AW       = (NREG > 1) ? $clog2(NREG) : 1,
   parameter int IW       = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_lock,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREG-1:0]    reg_en,
   output logic [DW-1:0]      reg_d,
   output logic               addr_err,
   output logic               locked,
   output logic [IW-1:0]      owner
);

   localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [CW-1:0] lock_cnt;
   logic [NREG-1:0] en_q;
   logic          err_q;

   logic [NREQ-1:0] pick_gnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;

   logic [IW-1:0] win;
   logic [IW-1:0] nxt;
   logic          acc;
   logic          expire;
   logic          w_lock;
   logic          in_rng;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic [NREG-1:0] en_n;

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // While owned, only the owner can be granted; reset blocks all grants.
   always_comb begin
      win       = pick_idx;
      req_ready = pick_gnt;
      if (state == OWNED) begin
         win            = owner;
         req_ready      = '0;
         req_ready[owner] = req_valid[owner];
      end
      if (reset) req_ready = '0;
   end

   assign acc    = |req_ready;
   assign w_lock = req_lock[win];
   assign w_addr = req_addr[int'(win)*AW +: AW];
   assign w_data = req_data[int'(win)*DW +: DW];
   assign in_rng = {1'b0, w_addr} < (AW+1)'(NREG);
   assign nxt    = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
   assign expire = (state == OWNED) && (lock_cnt == CW'(LOCK_MAX-1));
   assign en_n   = (acc && in_rng) ? NREG'(onehot(32'(w_addr))) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         lock_cnt <= '0;
         en_q     <= '0;
         err_q    <= 1'b0;
         reg_d    <= '0;
      end else begin
         en_q  <= en_n;
         err_q <= acc && !in_rng;
         if (acc) begin
            reg_d  <= w_data;
            owner  <= win;
            rr_ptr <= nxt;
         end
         unique case (state)
            IDLE: begin
               if (acc && w_lock) begin
                  state    <= OWNED;
                  lock_cnt <= '0;
               end
            end
            OWNED: begin
               if (expire || (acc && !w_lock)) begin
                  state    <= IDLE;
                  lock_cnt <= '0;
                  rr_ptr   <= nxt;
               end else begin
                  lock_cnt <= lock_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A write still sitting in the output register is dropped under reset.
   assign reg_en   = reset ? '0 : en_q;
   assign addr_err = err_q & ~reset;
   assign locked   = (state == OWNED);

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed table-driven bench for regbank_wr_arbiter.
// NREQ=4, NREG=6, DW=8, LOCK_MAX=4.
module tb_regbank_wr_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_lock;
   logic [11:0] req_addr;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [5:0]  reg_en;
   logic [7:0]  reg_d;
   logic        addr_err;
   logic        locked;
   logic [1:0]  owner;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regbank_wr_arbiter #(
      .NREQ     (4),
      .NREG     (6),
      .DW       (8),
      .LOCK_MAX (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .reg_en    (reg_en),
      .reg_d     (reg_d),
      .addr_err  (addr_err),
      .locked    (locked),
      .owner     (owner)
   );

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  rdy;
      logic [5:0]  en;
      logic [7:0]  q;
      logic        err;
      logic        lk;
      logic [1:0]  own;
   } vec_t;

   vec_t vq[$];

   localparam logic [11:0] A_ID = {3'd3, 3'd2, 3'd1, 3'd0};

   function automatic logic [31:0] dat(input logic [7:0] b);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic add(input logic [3:0] v, input logic [3:0] l,
                      input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] rdy, input logic [5:0] en,
                      input logic [7:0] q, input logic err,
                      input logic lk, input logic [1:0] own);
      vec_t x;
      x.v = v; x.l = l; x.a = a; x.d = d; x.rdy = rdy;
      x.en = en; x.q = q; x.err = err; x.lk = lk; x.own = own;
      vq.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l,
                        input logic [11:0] a, input logic [31:0] d);
      req_valid = v;
      req_lock  = l;
      req_addr  = a;
      req_data  = d;
   endtask

   initial begin
      int g;
      reset = 1'b1;
      drive(4'b1111, 4'b0000, A_ID, dat(8'h11));

      add(4'b0001, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd3}, dat(8'hA5),
          4'b0001, 6'b001000, 8'hA5, 1'b0, 1'b0, 2'd0);
      for (int k = 0; k < 8; k++) begin
         g = (k + 1) % 4;
         add(4'b1111, 4'b0000, A_ID, dat(8'h10),
             4'(1 << g), 6'(1 << g), 8'(8'h10 + g), 1'b0, 1'b0, 2'(g));
      end
      add(4'b0000, 4'b0000, A_ID, dat(8'h00),
          4'b0000, 6'b000000, 8'h10, 1'b0, 1'b0, 2'd0);
      add(4'b0111, 4'b0010, A_ID, dat(8'h20),
          4'b0010, 6'b000010, 8'h21, 1'b0, 1'b1, 2'd1);
      add(4'b0111, 4'b0010, {3'd0, 3'd2, 3'd4, 3'd0}, dat(8'h30),
          4'b0010, 6'b010000, 8'h31, 1'b0, 1'b1, 2'd1);
      add(4'b0101, 4'b0000, A_ID, dat(8'h30),
          4'b0000, 6'b000000, 8'h31, 1'b0, 1'b1, 2'd1);
      add(4'b0111, 4'b0000, {3'd0, 3'd2, 3'd5, 3'd0}, dat(8'h40),
          4'b0010, 6'b100000, 8'h41, 1'b0, 1'b0, 2'd1);
      add(4'b0101, 4'b0000, A_ID, dat(8'h50),
          4'b0100, 6'b000100, 8'h52, 1'b0, 1'b0, 2'd2);
      add(4'b0100, 4'b0100, {3'd0, 3'd1, 3'd0, 3'd0}, dat(8'h60),
          4'b0100, 6'b000010, 8'h62, 1'b0, 1'b1, 2'd2);
      for (int k = 0; k < 3; k++)
         add(4'b1000, 4'b0000, {3'd2, 3'd0, 3'd0, 3'd0}, dat(8'h70),
             4'b0000, 6'b000000, 8'h62, 1'b0, 1'b1, 2'd2);
      add(4'b1000, 4'b0000, {3'd2, 3'd0, 3'd0, 3'd0}, dat(8'h70),
          4'b0000, 6'b000000, 8'h62, 1'b0, 1'b0, 2'd2);
      add(4'b1000, 4'b0000, {3'd2, 3'd0, 3'd0, 3'd0}, dat(8'h70),
          4'b1000, 6'b000100, 8'h73, 1'b0, 1'b0, 2'd3);
      add(4'b0001, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd7}, dat(8'h80),
          4'b0001, 6'b000000, 8'h80, 1'b1, 1'b0, 2'd0);
      add(4'b0010, 4'b0000, {3'd0, 3'd0, 3'd6, 3'd0}, dat(8'h80),
          4'b0010, 6'b000000, 8'h81, 1'b1, 1'b0, 2'd1);
      add(4'b0100, 4'b0000, {3'd0, 3'd5, 3'd0, 3'd0}, dat(8'h80),
          4'b0100, 6'b100000, 8'h82, 1'b0, 1'b0, 2'd2);
      add(4'b0001, 4'b0001, A_ID, dat(8'h90),
          4'b0001, 6'b000001, 8'h90, 1'b0, 1'b1, 2'd0);
      add(4'b0011, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, dat(8'hA0),
          4'b0001, 6'b000010, 8'hA0, 1'b0, 1'b1, 2'd0);
      add(4'b0011, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, dat(8'hB0),
          4'b0001, 6'b000100, 8'hB0, 1'b0, 1'b1, 2'd0);
      add(4'b0011, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, dat(8'hC0),
          4'b0001, 6'b001000, 8'hC0, 1'b0, 1'b1, 2'd0);
      add(4'b0011, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd4}, dat(8'hD0),
          4'b0001, 6'b010000, 8'hD0, 1'b0, 1'b0, 2'd0);
      add(4'b1111, 4'b0000, A_ID, dat(8'hE0),
          4'b0010, 6'b000010, 8'hE1, 1'b0, 1'b0, 2'd1);

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(4'b0000, 4'b0000, A_ID, 32'h0);
      chk("rst_en", 32'(reg_en), 32'h0);
      chk("rst_d", 32'(reg_d), 32'h0);
      chk("rst_err", 32'(addr_err), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);

      foreach (vq[i]) begin
         drive(vq[i].v, vq[i].l, vq[i].a, vq[i].d);
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vq[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_en", i), 32'(reg_en), 32'(vq[i].en));
         chk($sformatf("v%0d_d", i), 32'(reg_d), 32'(vq[i].q));
         chk($sformatf("v%0d_err", i), 32'(addr_err), 32'(vq[i].err));
         chk($sformatf("v%0d_locked", i), 32'(locked), 32'(vq[i].lk));
         chk($sformatf("v%0d_owner", i), 32'(owner), 32'(vq[i].own));
      end

      // reset right after a locking accept drops the pending write
      drive(4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, dat(8'h55));
      @(negedge clk);
      chk("rl_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rl_ready_in_rst", 32'(req_ready), 32'h0);
      chk("rl_en_in_rst", 32'(reg_en), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(4'b0000, 4'b0000, A_ID, 32'h0);
      chk("rl_locked", 32'(locked), 32'h0);
      chk("rl_en", 32'(reg_en), 32'h0);
      chk("rl_owner", 32'(owner), 32'h0);
      drive(4'b1111, 4'b0000, A_ID, dat(8'hC5));
      @(negedge clk);
      chk("rl_next_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("rl_next_en", 32'(reg_en), 32'h01);
      chk("rl_next_d", 32'(reg_d), 32'hC5);
      chk("rl_next_locked", 32'(locked), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
